// File: rtl/gray_bin_pkg.sv
// Shared constants and the binary-to-Gray encode helper for the Gray converter.
package gray_bin_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 32;

    // Each Gray bit is the XOR of a binary bit and its upper neighbour.
    // The MSB is XORed with a zero-filled bit, so it passes through unchanged.
    // The function works on the widest legal code. Callers zero-extend their
    // input and keep the low WIDTH bits of the result. The extra bits are
    // zero, so truncating the result is exact.
    function automatic logic [MAX_WIDTH-1:0] binToGray(input logic [MAX_WIDTH-1:0] binVal);
        return binVal ^ (binVal >> 1);
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Purely combinational Gray-to-binary decoder (prefix XOR from the MSB down).
module gray_to_bin
    import gray_bin_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_binary
);

    // Walk from the MSB down, carrying the running XOR of all Gray bits seen so far.
    always_comb begin
        logic [WIDTH-1:0] w_acc;
        w_acc            = '0;
        w_acc[WIDTH-1]   = i_gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            w_acc[i] = w_acc[i+1] ^ i_gray[i];
        end
        o_binary = w_acc;
    end

endmodule

// File: rtl/gray_bin_converter.sv
// Registered Gray encoder/decoder with a built-in encode->decode self-check path.
module gray_bin_converter
    import gray_bin_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] binary_in,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] binary_out,
    output logic [WIDTH-1:0] roundtrip_out,
    output logic             roundtrip_err
);

    logic [WIDTH-1:0] w_grayEnc;
    logic [WIDTH-1:0] w_binDec;
    logic [WIDTH-1:0] w_roundtrip;
    logic             w_roundtripErr;

    logic             r_valid;
    logic [WIDTH-1:0] r_grayOut;
    logic [WIDTH-1:0] r_binaryOut;
    logic [WIDTH-1:0] r_roundtrip;
    logic             r_roundtripErr;

    // Encode through the package helper at full width and keep the low bits.
    assign w_grayEnc = WIDTH'(binToGray(MAX_WIDTH'(binary_in)));

    // This decoder serves the independent Gray input.
    gray_to_bin #(.WIDTH(WIDTH)) u_decodeGrayIn (
        .i_gray   (gray_in),
        .o_binary (w_binDec)
    );

    // This decoder undoes the local encode, so a healthy design reproduces binary_in.
    gray_to_bin #(.WIDTH(WIDTH)) u_decodeRoundtrip (
        .i_gray   (w_grayEnc),
        .o_binary (w_roundtrip)
    );

    assign w_roundtripErr = (w_roundtrip != binary_in);

    // Capture one result per valid cycle and hold the data when idle.
    // Reset wins over a transfer in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid        <= 1'b0;
            r_grayOut      <= '0;
            r_binaryOut    <= '0;
            r_roundtrip    <= '0;
            r_roundtripErr <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_grayOut      <= w_grayEnc;
                r_binaryOut    <= w_binDec;
                r_roundtrip    <= w_roundtrip;
                r_roundtripErr <= w_roundtripErr;
            end
        end
    end

    assign out_valid     = r_valid;
    assign gray_out      = r_grayOut;
    assign binary_out    = r_binaryOut;
    assign roundtrip_out = r_roundtrip;
    assign roundtrip_err = r_roundtripErr;

endmodule

// File: tb/tb_gray_bin_converter.sv
// Self-checking bench for gray_bin_converter.
// It drives three instances with WIDTH=4, WIDTH=1 and WIDTH=8 in lockstep.
module tb_gray_bin_converter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        inV[3];
    logic [31:0] inB[3];
    logic [31:0] inG[3];

    logic       o4v, o4e, o1v, o1e, o8v, o8e;
    logic [3:0] o4g, o4b, o4r;
    logic [0:0] o1g, o1b, o1r;
    logic [7:0] o8g, o8b, o8r;

    gray_bin_converter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(inV[0]),
        .binary_in(inB[0][3:0]), .gray_in(inG[0][3:0]),
        .out_valid(o4v), .gray_out(o4g), .binary_out(o4b),
        .roundtrip_out(o4r), .roundtrip_err(o4e)
    );

    gray_bin_converter #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(inV[1]),
        .binary_in(inB[1][0:0]), .gray_in(inG[1][0:0]),
        .out_valid(o1v), .gray_out(o1g), .binary_out(o1b),
        .roundtrip_out(o1r), .roundtrip_err(o1e)
    );

    gray_bin_converter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(inV[2]),
        .binary_in(inB[2][7:0]), .gray_in(inG[2][7:0]),
        .out_valid(o8v), .gray_out(o8g), .binary_out(o8b),
        .roundtrip_out(o8r), .roundtrip_err(o8e)
    );

    // Actual outputs, zero-extended so that one check routine covers every instance.
    logic        aV[3], aE[3];
    logic [31:0] aG[3], aB[3], aR[3];
    assign aV[0] = o4v;  assign aE[0] = o4e;
    assign aV[1] = o1v;  assign aE[1] = o1e;
    assign aV[2] = o8v;  assign aE[2] = o8e;
    assign aG[0] = {28'd0, o4g};  assign aB[0] = {28'd0, o4b};  assign aR[0] = {28'd0, o4r};
    assign aG[1] = {31'd0, o1g};  assign aB[1] = {31'd0, o1b};  assign aR[1] = {31'd0, o1r};
    assign aG[2] = {24'd0, o8g};  assign aB[2] = {24'd0, o8b};  assign aR[2] = {24'd0, o8r};

    int checks = 0;
    int errors = 0;

    // Reference model state: what each instance should show after the last edge.
    logic        mV[3], mE[3];
    logic [31:0] mG[3], mB[3], mR[3];

    function automatic int wOf(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 1 : 8);
    endfunction

    function automatic logic [31:0] maskOf(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Encode model: a value XORed with itself shifted right by one bit.
    function automatic logic [31:0] refEncode(input logic [31:0] b, input int w);
        return (b ^ (b >> 1)) & maskOf(w);
    endfunction

    // Decode model: binary bit i is the parity of every Gray bit at position i or above.
    function automatic logic [31:0] refDecode(input logic [31:0] g, input int w);
        logic [31:0] gm;
        logic [31:0] r;
        gm = g & maskOf(w);
        r  = '0;
        for (int i = 0; i < w; i++) r[i] = ^(gm >> i);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Callers place the inputs first. This task applies rst, advances the model,
    // clocks one edge, and then waits until just after that edge.
    task automatic applyStimulus(input logic r);
        rst = r;
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                mV[k] = 1'b0; mG[k] = '0; mB[k] = '0; mR[k] = '0; mE[k] = 1'b0;
            end else begin
                mV[k] = inV[k];
                if (inV[k]) begin
                    mG[k] = refEncode(inB[k], wOf(k));
                    mB[k] = refDecode(inG[k], wOf(k));
                    mR[k] = inB[k] & maskOf(wOf(k));
                    mE[k] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkModel(input string tag);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("%s w%0d out_valid", tag, wOf(k)), {31'd0, aV[k]}, {31'd0, mV[k]});
            checkOutput($sformatf("%s w%0d gray_out", tag, wOf(k)), aG[k], mG[k]);
            checkOutput($sformatf("%s w%0d binary_out", tag, wOf(k)), aB[k], mB[k]);
            checkOutput($sformatf("%s w%0d roundtrip_out", tag, wOf(k)), aR[k], mR[k]);
            checkOutput($sformatf("%s w%0d roundtrip_err", tag, wOf(k)), {31'd0, aE[k]}, {31'd0, mE[k]});
        end
    endtask

    typedef struct {
        logic       v;
        logic [3:0] b;
        logic [3:0] g;
        logic       expV;
        logic [3:0] expGray;
        logic [3:0] expBin;
        logic [3:0] expRt;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] prevG[3];

    initial begin
        // Directed WIDTH=4 vectors. The last entry is an idle cycle, which holds the previous outputs.
        vecs[0] = '{1'b1, 4'b1011, 4'b1110, 1'b1, 4'b1110, 4'b1011, 4'b1011};
        vecs[1] = '{1'b1, 4'b1000, 4'b0000, 1'b1, 4'b1100, 4'b0000, 4'b1000};
        vecs[2] = '{1'b1, 4'b1111, 4'b1000, 1'b1, 4'b1000, 4'b1111, 4'b1111};
        vecs[3] = '{1'b1, 4'b0101, 4'b0111, 1'b1, 4'b0111, 4'b0101, 4'b0101};
        vecs[4] = '{1'b0, 4'b1010, 4'b0000, 1'b0, 4'b0111, 4'b0101, 4'b0101};

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            inV[k] = 1'b0; inB[k] = '0; inG[k] = '0;
        end
        applyStimulus(1'b1);
        inV[0] = 1'b1; inB[0] = 32'hF; inG[0] = 32'hF;
        applyStimulus(1'b1);
        checkOutput("reset out_valid", {31'd0, aV[0]}, 32'd0);
        checkOutput("reset gray_out", aG[0], 32'd0);
        checkOutput("reset binary_out", aB[0], 32'd0);
        checkOutput("reset roundtrip_out", aR[0], 32'd0);
        checkModel("reset");

        // The first vector follows reset directly, with no idle cycle between them.
        for (int i = 0; i < 5; i++) begin
            inV[0] = vecs[i].v; inB[0] = {28'd0, vecs[i].b}; inG[0] = {28'd0, vecs[i].g};
            applyStimulus(1'b0);
            checkOutput($sformatf("vec%0d out_valid", i), {31'd0, aV[0]}, {31'd0, vecs[i].expV});
            checkOutput($sformatf("vec%0d gray_out", i), aG[0], {28'd0, vecs[i].expGray});
            checkOutput($sformatf("vec%0d binary_out", i), aB[0], {28'd0, vecs[i].expBin});
            checkOutput($sformatf("vec%0d roundtrip_out", i), aR[0], {28'd0, vecs[i].expRt});
            checkOutput($sformatf("vec%0d roundtrip_err", i), {31'd0, aE[0]}, 32'd0);
        end

        // A reset arriving mid-stream, while a transfer is valid, discards that transfer.
        inV[0] = 1'b1; inB[0] = 32'h3; inG[0] = 32'h2;
        applyStimulus(1'b0);
        checkOutput("pre-reset gray_out", aG[0], 32'h2);
        inB[0] = 32'hC; inG[0] = 32'hA;
        applyStimulus(1'b1);
        checkOutput("midreset out_valid", {31'd0, aV[0]}, 32'd0);
        checkOutput("midreset gray_out", aG[0], 32'd0);
        checkOutput("midreset binary_out", aB[0], 32'd0);
        checkOutput("midreset roundtrip_out", aR[0], 32'd0);
        inB[0] = 32'h6; inG[0] = 32'h4;
        applyStimulus(1'b0);
        checkOutput("postreset out_valid", {31'd0, aV[0]}, 32'd1);
        checkOutput("postreset gray_out", aG[0], 32'h5);
        checkOutput("postreset binary_out", aB[0], 32'h7);
        checkModel("postreset");

        // Exhaustive sweep, one value per cycle on every width.
        // Every step must change exactly one Gray bit, including the wrap to zero.
        for (int i = 0; i <= 256; i++) begin
            for (int k = 0; k < 3; k++) begin
                inV[k] = 1'b1;
                inB[k] = i & maskOf(wOf(k));
                inG[k] = $urandom & maskOf(wOf(k));
            end
            applyStimulus(1'b0);
            checkModel("sweep");
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("sweep w%0d roundtrip=input", wOf(k)), aR[k], inB[k]);
                if (i > 0)
                    checkOutput($sformatf("sweep w%0d gray step bits", wOf(k)),
                                $countones(prevG[k] ^ aG[k]), 32'd1);
                prevG[k] = aG[k];
            end
        end

        // Randomised traffic: valid gaps, independent inputs and occasional resets.
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 3; k++) begin
                inV[k] = ($urandom_range(0, 3) != 0);
                inB[k] = $urandom & maskOf(wOf(k));
                inG[k] = $urandom & maskOf(wOf(k));
            end
            applyStimulus($urandom_range(0, 19) == 0);
            checkModel("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_bin_converter.md
GRAY_BIN_CONVERTER -- requirements
Module: gray_bin_converter

Interface
REQ-001 Parameter WIDTH, default 4: code width in bits; legal range 1..32.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  qualifies binary_in and gray_in in the current cycle.
REQ-006 binary_in  input  WIDTH  binary value to encode.
REQ-007 gray_in  input  WIDTH  Gray value to decode.
REQ-008 out_valid  output  1  registered copy of in_valid.
REQ-009 gray_out  output  WIDTH  registered Gray encoding of binary_in.
REQ-010 binary_out  output  WIDTH  registered binary decoding of gray_in.
REQ-011 roundtrip_out  output  WIDTH  registered decode of the encode of binary_in.
REQ-012 roundtrip_err  output  1  registered flag, high when roundtrip_out differs from the captured binary_in.

Function
REQ-013 Encode: gray[WIDTH-1] = b[WIDTH-1]; gray[i] = b[i+1] XOR b[i] for i < WIDTH-1.
REQ-014 Decode: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] XOR g[i] for i < WIDTH-1 (prefix XOR from MSB).
REQ-015 Latency is exactly 1 cycle: inputs sampled with in_valid=1 at edge N appear on outputs after edge N; out_valid=1 in that cycle.
REQ-016 With in_valid=0 at an edge: out_valid goes 0; gray_out, binary_out, roundtrip_out and roundtrip_err hold their previous values.
REQ-017 Back-to-back in_valid=1 cycles are accepted every cycle; no backpressure and no stall.
REQ-018 Encode and decode paths are independent; gray_in need not relate to binary_in.
REQ-019 roundtrip_err is computed combinationally from the same sampled binary_in; in a correct design it is always 0.
REQ-020 Wrap-around: binary all-ones to all-zeros maps to Gray 100..0 to 000..0; exactly one bit changes.
REQ-021 WIDTH=1: all conversions are identity.

Reset
REQ-022 rst=1 at a rising edge forces out_valid=0 and clears gray_out, binary_out, roundtrip_out and roundtrip_err to 0.
REQ-023 rst has priority over in_valid; a transfer coinciding with reset is discarded.
REQ-024 The first accepted transfer after reset deasserts needs no idle cycle.

Structure
REQ-025 Package gray_bin_pkg holds the default WIDTH constant and the encode function.
REQ-026 Decode is a combinational sub-module gray_to_bin, parameterized by WIDTH, instantiated twice: once for gray_in and once for the round-trip path.
REQ-027 All registers reside in the top module; no latches and no combinational feedback.

Verification
REQ-028 WIDTH=4, binary_in=1011, gray_in=1110, in_valid=1 -> next cycle gray_out=1110, binary_out=1011, roundtrip_out=1011, roundtrip_err=0, out_valid=1.
REQ-029 binary_in=1000 -> gray_out=1100; binary_in=1111 -> gray_out=1000; both round-trip exactly.
REQ-030 Exhaustive sweep of binary_in 0..15, one per cycle -> roundtrip_out equals input every cycle; consecutive gray_out values differ in exactly one bit, including 15 to 0.
REQ-031 in_valid=1 (binary_in=0101), then in_valid=0 with binary_in=1010 -> out_valid drops and gray_out holds 0111.
REQ-032 Assert rst while in_valid=1 mid-stream -> all outputs 0 and out_valid=0 next cycle; the next valid input is processed normally.
REQ-033 Repeat the exhaustive round-trip check with WIDTH=1 and WIDTH=8 (256 values).
